// File: rtl/accel_compr_ctrl.sv
// Sequencing controller for a block-hash accelerator. It walks a job of
// nblocks 512-bit blocks through fetch, compressor init (first block only),
// round issue and a fixed-length hash window. It also handles abort,
// zero-length jobs and a missing-completion timeout.
module accel_compr_ctrl #(
    parameter int unsigned TIMEOUT = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] nblocks,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       blk_req,
    input  logic       blk_ack,
    output logic [5:0] blk_idx,
    output logic       ms_enable,
    output logic       cm_init,
    output logic       cm_enable,
    input  logic       hash_done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StInit,
        StIssue,
        StHash,
        StDrain,
        StFin,
        StErr
    } state_e;

    // Last HASH count value at which a missing hash_done is still tolerated.
    localparam logic [6:0] CntLast = 7'(TIMEOUT - 1);
    // The scheduler window: cnt 1..64 inclusive.
    localparam logic [6:0] MsFirst = 7'd1;
    localparam logic [6:0] MsLast  = 7'd64;

    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [5:0] blk_idx_q, blk_idx_d;
    logic [5:0] nblk_q, nblk_d;
    logic       first_q, first_d;
    logic       last_blk;

    assign last_blk = (blk_idx_q == (nblk_q - 6'd1));

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 7'd0;
            blk_idx_q <= 6'd0;
            nblk_q    <= 6'd0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blk_idx_q <= blk_idx_d;
            nblk_q    <= nblk_d;
            first_q   <= first_d;
        end
    end

    // Next-state, counter and block-index update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blk_idx_d = blk_idx_q;
        nblk_d    = nblk_q;
        first_d   = first_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (nblocks != 6'd0) begin
                        nblk_d    = nblocks;
                        blk_idx_d = 6'd0;
                        first_d   = 1'b1;
                        state_d   = StFetch;
                    end else begin
                        state_d = StErr;
                    end
                end
            end

            StFetch: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (blk_ack) begin
                    // Only the first block of a job reloads the initial hash.
                    state_d = first_q ? StInit : StIssue;
                end
            end

            StInit: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    first_d = 1'b0;
                    state_d = StIssue;
                end
            end

            StIssue: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = 7'd0;
                    state_d = StHash;
                end
            end

            StHash: begin
                cnt_d = cnt_q + 7'd1;
                if (abort && hash_done) begin
                    state_d = StIdle;
                end else if (abort) begin
                    // Let the in-flight round finish before going idle.
                    state_d = StDrain;
                end else if (hash_done) begin
                    if (last_blk) begin
                        state_d = StFin;
                    end else begin
                        blk_idx_d = blk_idx_q + 6'd1;
                        state_d   = StFetch;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = StErr;
                end
            end

            StDrain: begin
                cnt_d = cnt_q + 7'd1;
                // >= covers an abort landing on the timeout cycle itself.
                if (hash_done || (cnt_q >= CntLast)) begin
                    state_d = StIdle;
                end
            end

            StFin: begin
                state_d = StIdle;
            end

            StErr: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded purely from registered state and counters.
    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StFin);
        err       = (state_q == StErr);
        blk_req   = (state_q == StFetch);
        cm_init   = (state_q == StInit);
        cm_enable = (state_q == StIssue);
        ms_enable = ((state_q == StHash) || (state_q == StDrain)) &&
                    (cnt_q >= MsFirst) && (cnt_q <= MsLast);
        blk_idx   = blk_idx_q;
    end

endmodule

// File: tb/tb_accel_compr_ctrl.sv
// Self-checking bench for accel_compr_ctrl. Expected compressor events
// (cm_init, cm_enable, done, err) are queued with their cycle numbers when a
// job is started and popped by a negedge monitor as the DUT produces them.
module tb_accel_compr_ctrl;

    localparam int unsigned TIMEOUT = 80;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] nblocks;
    logic       abort;
    logic       busy;
    logic       done;
    logic       err;
    logic       blk_req;
    logic       blk_ack;
    logic [5:0] blk_idx;
    logic       ms_enable;
    logic       cm_init;
    logic       cm_enable;
    logic       hash_done;

    accel_compr_ctrl #(
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .nblocks  (nblocks),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .blk_req  (blk_req),
        .blk_ack  (blk_ack),
        .blk_idx  (blk_idx),
        .ms_enable(ms_enable),
        .cm_init  (cm_init),
        .cm_enable(cm_enable),
        .hash_done(hash_done)
    );

    // Event kinds: 1 cm_init, 2 cm_enable, 3 done, 4 err.
    typedef struct {
        int kind;
        int cyc;
        int idx;
    } ev_t;

    ev_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Environment model knobs.
    int ack_delay = 0;
    bit hd_en     = 1'b1;
    int hd_at     = -1;
    int req_age   = 0;

    // Per-test observations.
    int ms_cnt, ms_first, ms_last, req_first;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scheduler/compressor model: ack after ack_delay cycles of blk_req,
    // hash_done 68 cycles after each cm_enable.
    initial begin
        blk_ack   = 1'b0;
        hash_done = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            hash_done = hd_en && (cyc == hd_at);
            if (cm_enable) hd_at = cyc + 68;
            if (blk_req) req_age = req_age + 1;
            else         req_age = 0;
            blk_ack = blk_req && (req_age > ack_delay);
        end
    end

    // Scoreboard monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cm_init && cm_enable) begin
                    n_checks = n_checks + 1;
                    n_fail   = n_fail + 1;
                    $display("FAIL init_enable_overlap cyc=%0d", cyc);
                end
                if (ms_enable) begin
                    ms_cnt = ms_cnt + 1;
                    if (ms_first < 0) ms_first = cyc;
                    ms_last = cyc;
                end
                if (blk_req && req_first < 0) req_first = cyc;
                for (int k = 1; k <= 4; k++) begin
                    logic hit;
                    ev_t  e;
                    hit = (k == 1) ? cm_init : (k == 2) ? cm_enable :
                          (k == 3) ? done : err;
                    if (hit) begin
                        n_checks = n_checks + 1;
                        if (exp_q.size() == 0) begin
                            n_fail = n_fail + 1;
                            $display("FAIL unexpected_event kind=%0d cyc=%0d", k, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.kind !== k || e.cyc !== cyc ||
                                (k == 2 && e.idx !== int'(blk_idx))) begin
                                n_fail = n_fail + 1;
                                $display("FAIL event got kind=%0d cyc=%0d idx=%0d exp kind=%0d cyc=%0d idx=%0d",
                                         k, cyc, blk_idx, e.kind, e.cyc, e.idx);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int c, input int idx);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    task automatic clear_obs();
        ms_cnt    = 0;
        ms_first  = -1;
        ms_last   = -1;
        req_first = -1;
    endtask

    // Pulse start for one cycle; returns the cycle start was high in.
    task automatic kick(input logic [5:0] nb, output int s);
        step();
        s       = cyc;
        start   = 1'b1;
        nblocks = nb;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n = n + 1;
        end
        n_checks = n_checks + 1;
        if (busy) begin
            n_fail = n_fail + 1;
            $display("FAIL %s_idle_timeout busy=%0b required=0", name, busy);
        end
        n_checks = n_checks + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL %s_missing_events left=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        start   = 1'b0;
        nblocks = 6'd0;
        abort   = 1'b0;
        repeat (3) step();
        n_checks = n_checks + 1;
        if ({busy, done, err, blk_req, ms_enable, cm_init, cm_enable, blk_idx} !== 13'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_outputs got=%b required=0",
                     {busy, done, err, blk_req, ms_enable, cm_init, cm_enable, blk_idx});
        end
        rst_n = 1'b1;
        repeat (2) step();
        n_checks = n_checks + 1;
        if ({cm_init, cm_enable, busy} !== 3'b000) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_quiet got=%b required=000", {cm_init, cm_enable, busy});
        end
    endtask

    task automatic test_single_block();
        int s;
        ack_delay = 0;
        hd_en     = 1'b1;
        clear_obs();
        step();
        s = cyc + 1;
        push(1, s + 2, 0);
        push(2, s + 3, 0);
        push(3, s + 72, 0);
        kick(6'd1, s);
        while (cyc < s + 72) step();
        n_checks = n_checks + 1;
        if (busy !== 1'b1 || done !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL single_done_cycle busy=%0b done=%0b required=1 1", busy, done);
        end
        step();
        n_checks = n_checks + 1;
        if (busy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL single_busy_low got=%0b required=0", busy);
        end
        n_checks = n_checks + 1;
        if (req_first !== s + 1) begin
            n_fail = n_fail + 1;
            $display("FAIL single_blk_req got=%0d required=%0d", req_first, s + 1);
        end
        n_checks = n_checks + 1;
        if (ms_cnt !== 64 || ms_first !== s + 5 || ms_last !== s + 68) begin
            n_fail = n_fail + 1;
            $display("FAIL single_ms_window got=%0d %0d..%0d required=64 %0d..%0d",
                     ms_cnt, ms_first, ms_last, s + 5, s + 68);
        end
        wait_idle("single", 10);
    endtask

    task automatic test_three_blocks();
        int s, t, fe, iss;
        ack_delay = 5;
        hd_en     = 1'b1;
        clear_obs();
        step();
        s = cyc + 1;
        t = s + 1;
        for (int b = 0; b < 3; b++) begin
            fe = t + ack_delay;
            if (b == 0) begin
                push(1, fe + 1, 0);
                iss = fe + 2;
            end else begin
                iss = fe + 1;
            end
            push(2, iss, b);
            t = iss + 69;
        end
        push(3, t, 0);
        kick(6'd3, s);
        wait_idle("three", 400);
        n_checks = n_checks + 1;
        if (ms_cnt !== 192) begin
            n_fail = n_fail + 1;
            $display("FAIL three_ms_count got=%0d required=192", ms_cnt);
        end
        n_checks = n_checks + 1;
        if (blk_idx !== 6'd2) begin
            n_fail = n_fail + 1;
            $display("FAIL three_idx_hold got=%0d required=2", blk_idx);
        end
        ack_delay = 0;
    endtask

    task automatic test_zero_len();
        int s;
        clear_obs();
        step();
        s = cyc + 1;
        push(4, s + 1, 0);
        kick(6'd0, s);
        wait_idle("zero", 10);
        n_checks = n_checks + 1;
        if (req_first !== -1 || ms_cnt !== 0) begin
            n_fail = n_fail + 1;
            $display("FAIL zero_activity req=%0d ms=%0d required=-1 0", req_first, ms_cnt);
        end
    endtask

    task automatic test_timeout();
        int s;
        hd_en = 1'b0;
        clear_obs();
        step();
        s = cyc + 1;
        push(1, s + 2, 0);
        push(2, s + 3, 0);
        // HASH entered at s+4 with cnt=0, so cnt=TIMEOUT-1 at s+3+TIMEOUT.
        push(4, s + 4 + TIMEOUT, 0);
        kick(6'd1, s);
        while (cyc < s + 5 + TIMEOUT) step();
        n_checks = n_checks + 1;
        if (busy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL timeout_idle got=%0b required=0", busy);
        end
        wait_idle("timeout", 10);
        hd_en = 1'b1;
        hd_at = -1;
    endtask

    task automatic test_abort_drain();
        int s;
        hd_en = 1'b1;
        clear_obs();
        step();
        s = cyc + 1;
        push(1, s + 2, 0);
        push(2, s + 3, 0);
        kick(6'd2, s);
        while (cyc < s + 23) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        while (cyc < s + 71) step();
        n_checks = n_checks + 1;
        if (busy !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL abort_drain_busy got=%0b required=1", busy);
        end
        step();
        n_checks = n_checks + 1;
        if (busy !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL abort_drain_idle got=%0b required=0", busy);
        end
        repeat (5) step();
        n_checks = n_checks + 1;
        if (ms_cnt !== 64) begin
            n_fail = n_fail + 1;
            $display("FAIL abort_ms_count got=%0d required=64", ms_cnt);
        end
        wait_idle("abort", 10);
    endtask

    task automatic test_reset_midhash();
        int s;
        clear_obs();
        step();
        s = cyc + 1;
        push(1, s + 2, 0);
        push(2, s + 3, 0);
        kick(6'd1, s);
        // cnt=30 at s+34.
        while (cyc < s + 34) step();
        rst_n = 1'b0;
        step();
        hd_at = -1;
        n_checks = n_checks + 1;
        if ({busy, done, err, blk_req, ms_enable, cm_init, cm_enable, blk_idx} !== 13'd0) begin
            n_fail = n_fail + 1;
            $display("FAIL midreset_outputs got=%b required=0",
                     {busy, done, err, blk_req, ms_enable, cm_init, cm_enable, blk_idx});
        end
        rst_n = 1'b1;
        n_checks = n_checks + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL midreset_events left=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) step();
        test_single_block();
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_three_blocks();
        test_zero_len();
        test_timeout();
        test_abort_drain();
        test_reset_midhash();
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
